// File: rtl/piso_unloader.sv
// Purpose: parallel-to-serial unloader; emits an n-bit word as W = n/m beats of m bits, LSB beat first.
// Latency: first beat is valid one cycle after load; back-to-back words stream with no bubble.
// Backpressure: out_ready=0 freezes the current beat; in_ready only opens in IDLE or on an accepted final beat.
module piso_unloader #(
  parameter int n = 1344,
  parameter int m = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] data_in,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [m-1:0] data_out,
  output logic         last
);

  localparam int W  = n / m;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  logic [n-1:0]    sreg;
  logic [CW-1:0]   cnt;
  logic            last_beat;

  // Beat W-1 is the final beat of the word currently in the shift register.
  assign last_beat = (state == SEND) && (cnt == CNT_LAST);

  // sreg is cleared whenever IDLE is entered, so the low beat already reads 0 there.
  assign out_valid = (state == SEND);
  assign last      = last_beat;
  assign data_out  = sreg[m-1:0];

  // Accept a new word when idle, or exactly as the final beat leaves; never during reset or flush.
  assign in_ready  = !rst && !flush && ((state == IDLE) || (last_beat && out_ready));

  // FSM, beat counter and shift register; flush outranks both handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= data_in;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (!last_beat) begin
              sreg <= sreg >> m;
              cnt  <= cnt + CW'(1);
            end else if (in_valid) begin
              // Chain straight into the next word so out_valid never drops.
              sreg  <= data_in;
              cnt   <= '0;
              state <= SEND;
            end else begin
              sreg  <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          sreg  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_unloader.sv
// Directed bench for piso_unloader: full-size (21 beats) and small (2 beats) instances.
// Inputs change on the falling edge; outputs are checked on the falling edge or 1 time unit later.
// Expected beats are built from the stimulus word pattern, never read back from the design.
module tb_piso_unloader;

  localparam int NB = 1344;
  localparam int MB = 64;
  localparam int WB = NB / MB;
  localparam int NS = 128;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] data_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [MB-1:0] data_out;
  logic          last;

  logic          s_in_valid;
  logic          s_in_ready;
  logic [NS-1:0] s_data_in;
  logic          s_flush;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [MB-1:0] s_data_out;
  logic          s_last;

  int total;
  int bad;

  piso_unloader #(.n(NB), .m(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .last      (last)
  );

  piso_unloader #(.n(NS), .m(MB)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .data_in   (s_data_in),
    .flush     (s_flush),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .data_out  (s_data_out),
    .last      (s_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word whose beat k is base + k.
  function automatic logic [NB-1:0] mk_word(input logic [63:0] base);
    logic [NB-1:0] w;
    w = '0;
    for (int k = 0; k < WB; k++) w[k*MB +: MB] = base + 64'(k);
    return w;
  endfunction

  task automatic chk_beat(input string tag, input logic [63:0] base, input int k);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  data_out, base + 64'(k));
    chk({tag, "_last"},  64'(last), (k == WB - 1) ? 64'd1 : 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"},  data_out, 64'd0);
    chk({tag, "_last"},  64'(last), 64'd0);
  endtask

  // Present a word at the current falling edge; returns with beat 0 showing.
  task automatic load_word(input logic [63:0] base);
    in_valid = 1'b1;
    data_in  = mk_word(base);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    int pulses;

    total = 0;
    bad   = 0;
    rst = 1'b1;
    in_valid = 1'b0; data_in = '0; flush = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_data_in = '0; s_flush = 1'b0; s_out_ready = 1'b0;

    // Reset state
    #2;
    chk_idle("rst");
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk_idle("rel");

    // Basic: 21 consecutive beats with out_ready held high
    out_ready = 1'b1;
    load_word(64'h1000);
    for (int i = 0; i < WB; i++) begin
      chk_beat("basic", 64'h1000, i);
      @(negedge clk);
    end
    chk_idle("basic_end");

    // Backpressure: out_ready pattern 1,0,0 repeating
    load_word(64'h1000);
    k = 0;
    cyc = 0;
    while (k < WB && cyc < 200) begin
      chk_beat("bp", 64'h1000, k);
      out_ready = ((cyc % 3) == 0);
      @(negedge clk);
      if (out_ready) k++;
      cyc++;
    end
    chk("bp_beats", 64'(k), 64'(WB));
    chk_idle("bp_end");
    out_ready = 1'b1;

    // Back-to-back: B offered during A's final beat
    load_word(64'h1000);
    pulses = 0;
    for (int i = 0; i < WB; i++) begin
      chk_beat("b2b_a", 64'h1000, i);
      if (i == WB - 1) begin
        in_valid = 1'b1;
        data_in  = mk_word(64'h2000);
      end
      #1;
      if (in_ready) pulses++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'd1);
    for (int i = 0; i < WB; i++) begin
      chk_beat("b2b_b", 64'h2000, i);
      @(negedge clk);
    end
    chk_idle("b2b_end");

    // Flush after beat 5 of A
    load_word(64'h1000);
    for (int i = 0; i < 6; i++) begin
      chk_beat("fl_a", 64'h1000, i);
      @(negedge clk);
    end
    chk_beat("fl_a6", 64'h1000, 6);
    flush = 1'b1;
    in_valid = 1'b1;
    data_in = mk_word(64'h3000);
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk_idle("fl_idle");
    load_word(64'h2000);
    for (int i = 0; i < WB; i++) begin
      chk_beat("fl_b", 64'h2000, i);
      @(negedge clk);
    end
    chk_idle("fl_end");

    // Async reset while beat 10 is held
    load_word(64'h1000);
    for (int i = 0; i < 10; i++) @(negedge clk);
    out_ready = 1'b0;
    chk_beat("ar_b10", 64'h1000, 10);
    #2;
    rst = 1'b1;
    in_valid = 1'b1;
    data_in = mk_word(64'h3000);
    #1;
    chk_idle("ar_rst");
    chk("ar_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk_idle("ar_hold");
    in_valid = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("ar_rel_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk_idle("ar_noload");
    load_word(64'h2000);
    chk_beat("ar_new", 64'h2000, 0);
    for (int i = 0; i < WB; i++) @(negedge clk);
    chk_idle("ar_end");

    // Small configuration: W = 2
    s_out_ready = 1'b1;
    #1;
    chk("s_in_ready", 64'(s_in_ready), 64'd1);
    s_in_valid = 1'b1;
    s_data_in = {64'h00A1, 64'h00A0};
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("s_b0_valid", 64'(s_out_valid), 64'd1);
    chk("s_b0_data",  s_data_out, 64'h00A0);
    chk("s_b0_last",  64'(s_last), 64'd0);
    @(negedge clk);
    chk("s_b1_valid", 64'(s_out_valid), 64'd1);
    chk("s_b1_data",  s_data_out, 64'h00A1);
    chk("s_b1_last",  64'(s_last), 64'd1);
    @(negedge clk);
    chk("s_end_valid", 64'(s_out_valid), 64'd0);
    chk("s_end_data",  s_data_out, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_unloader.md
PISO_UNLOADER -- requirements
Module: piso_unloader

Interface
REQ-001 The block SHALL have parameter n, default 1344, meaning parallel word width in bits.
REQ-002 The block SHALL have parameter m, default 64, meaning serial beat width in bits; n SHALL be a multiple of m, and W = n/m SHALL be >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: data_in holds a word to load.
REQ-006 The block SHALL have port in_ready, output, 1 bit: a load is accepted this cycle if in_valid is also 1.
REQ-007 The block SHALL have port data_in, input, n bits: the parallel word.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous abort of the word in progress.
REQ-009 The block SHALL have port out_valid, output, 1 bit: data_out holds a valid beat.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the sink accepts the beat.
REQ-011 The block SHALL have port data_out, output, m bits: the current beat.
REQ-012 The block SHALL have port last, output, 1 bit: the current beat is beat W-1 of the word.

Function
REQ-013 The block SHALL be the parallel-to-serial counterpart of the serial-to-parallel collector. Beat k SHALL be data_in[m*k+m-1 : m*k], for k = 0..W-1, sent in ascending k (LSB word first).
REQ-014 The block SHALL hold an n-bit shift register sreg, a beat counter cnt of width clog2(W), and a 2-state FSM with states IDLE and SEND.
REQ-015 in_ready SHALL be combinational: 1 in IDLE, or in SEND when last=1 and out_ready=1. in_ready SHALL be 0 whenever flush=1.
REQ-016 IDLE: in_valid and in_ready with flush=0 SHALL load sreg <= data_in, set cnt <= 0 and go to SEND; out_valid SHALL rise on the next cycle (load-to-first-beat latency of 1 cycle).
REQ-017 SEND: out_valid=1, data_out = sreg[m-1:0], last = (cnt == W-1).
REQ-018 SEND beat handshake: out_valid and out_ready with last=0 SHALL shift sreg right by m (zero fill) and increment cnt.
REQ-019 SEND with out_valid=1 and out_ready=0 SHALL hold data_out, last, sreg and cnt stable.
REQ-020 Final beat accepted (last and out_ready) with in_valid=1 SHALL load the new word and stay in SEND with cnt <= 0, so there is no bubble between words.
REQ-021 Final beat accepted with in_valid=0 SHALL go to IDLE and clear cnt.
REQ-022 flush=1 in any state SHALL go to IDLE next cycle, clear cnt and sreg, and discard the remaining beats. flush SHALL take priority over both handshakes.
REQ-023 A word SHALL take exactly W accepted beats; cnt SHALL never exceed W-1.
REQ-024 In IDLE: out_valid=0, last=0, data_out=0.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, cnt=0 and sreg=0, giving out_valid=0, last=0 and data_out=0.
REQ-026 While rst=1, in_ready SHALL be 0 and no load SHALL occur. in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-027 rst asserted mid-word SHALL discard the word; the first beat after reset SHALL come from a new load.

Verification
REQ-028 Basic (n=1344, m=64): load data_in with word k = 64'h1000+k, hold out_ready=1 -> 21 consecutive beats 0x1000..0x1014, last only on 0x1014, then out_valid=0.
REQ-029 Backpressure: toggle out_ready 1,0,0,1... -> each beat held stable while out_ready=0, no beat duplicated or dropped, 21 beats total.
REQ-030 Back-to-back: in_valid=1 with word B present at A's last beat -> B beat 0 on the next cycle, no out_valid gap, in_ready pulses exactly once.
REQ-031 Flush: assert flush after beat 5 of A -> out_valid=0 next cycle; the next load emits only the new word's beats starting at beat 0.
REQ-032 Async reset: rst pulse between clock edges during beat 10 -> out_valid, last and data_out go to 0 immediately; in_ready=0 during reset and 1 in the cycle after release.
REQ-033 Small configuration (n=128, m=64, W=2): single load -> exactly 2 beats, last on the second.
